// File: rtl/fetch_pkg.sv
// fetch_pkg: shared entry type and constants for the fetch stage.
package fetch_pkg;
    localparam int XLEN    = 32;
    localparam int EPOCH_W = 1;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of fetch entries with occupancy count.
// Clear wins over push and pop; DEPTH must be a power of two so pointers wrap naturally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  T                           i_din,
    input  logic                       i_pop,
    output T                           o_dout,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push && !i_clr) r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PTR_W'(1);
            if (i_pop) r_rd <= r_rd + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: owns the PC, issues sequential BRAM reads and buffers returns for decode.
// Redirects toggle a 1-bit epoch so in-flight returns from the old path are dropped on arrival.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               DEPTH        = 4,
    parameter int               BRAM_LATENCY = 1,
    parameter logic [WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [WIDTH-1:0]           im_addr,
    output logic                       im_en,
    input  logic [WIDTH-1:0]           im_instr,
    input  logic                       redirect_valid,
    input  logic [WIDTH-1:0]           redirect_pc,
    input  logic                       stall,
    output logic                       instr_valid,
    output logic [WIDTH-1:0]           instrF,
    output logic [WIDTH-1:0]           pcF,
    output logic [WIDTH-1:0]           pc_plus4F,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int L     = BRAM_LATENCY;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    logic [WIDTH-1:0]   r_fetch_pc;
    logic [EPOCH_W-1:0] r_epoch;
    logic [L-1:0]       r_pipe_v;
    logic [EPOCH_W-1:0] r_pipe_ep [L];
    logic [WIDTH-1:0]   r_pipe_pc [L];

    logic [L-1:0]     w_live;
    logic             w_ret;
    logic [CNT_W-1:0] w_inflight;
    logic [CNT_W:0]   w_used;
    logic [CNT_W-1:0] w_q_count;
    logic             w_q_empty;
    logic             w_q_push;
    logic             w_q_pop;
    logic             w_pop;
    entry_t           w_q_head;
    entry_t           w_ret_entry;
    entry_t           w_head;

    // Only current-epoch requests hold a credit; the last stage is the word returning now.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < L; i++) begin
            w_live[i] = r_pipe_v[i] && (r_pipe_ep[i] == r_epoch);
            if (i < L - 1) w_inflight = w_inflight + CNT_W'(w_live[i]);
        end
    end

    assign w_ret     = w_live[L-1];
    assign occupancy = w_q_count + CNT_W'(w_ret);
    assign w_used    = {1'b0, occupancy} + {1'b0, w_inflight};
    assign im_en     = rst && !redirect_valid && (w_used < (CNT_W+1)'(DEPTH));
    assign im_addr   = r_fetch_pc;

    // An empty queue exposes the returning word directly so it needs no extra cycle.
    assign w_ret_entry = {r_pipe_pc[L-1], im_instr};
    assign w_head      = w_q_empty ? w_ret_entry : w_q_head;
    assign instr_valid = !w_q_empty || w_ret;
    assign w_pop       = instr_valid && !stall;
    assign w_q_pop     = w_pop && !w_q_empty;
    assign w_q_push    = w_ret && !(w_q_empty && w_pop);

    assign instrF    = instr_valid ? w_head.instr : '0;
    assign pcF       = instr_valid ? w_head.pc : '0;
    assign pc_plus4F = instr_valid ? w_head.pc + WIDTH'(PC_STEP) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_epoch    <= '0;
            r_pipe_v   <= '0;
            for (int i = 0; i < L; i++) begin
                r_pipe_ep[i] <= '0;
                r_pipe_pc[i] <= '0;
            end
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc & ~WIDTH'(PC_STEP - 1);
                r_epoch    <= ~r_epoch;
            end else if (im_en) begin
                r_fetch_pc <= r_fetch_pc + WIDTH'(PC_STEP);
            end
            r_pipe_v[0]  <= im_en;
            r_pipe_ep[0] <= r_epoch;
            r_pipe_pc[0] <= r_fetch_pc;
            for (int i = 1; i < L; i++) begin
                r_pipe_v[i]  <= r_pipe_v[i-1];
                r_pipe_ep[i] <= r_pipe_ep[i-1];
                r_pipe_pc[i] <= r_pipe_pc[i-1];
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (redirect_valid),
        .i_push  (w_q_push),
        .i_din   (w_ret_entry),
        .i_pop   (w_q_pop),
        .o_dout  (w_q_head),
        .o_count (w_q_count),
        .o_empty (w_q_empty)
    );
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: drives latency-1 and latency-2 instances with shared stimulus
// and checks each against an in-order program-stream model.
module tb_fetch_prefetch_unit;
    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] im_addr1, im_instr1, ins1, pc1, p41;
    logic [31:0] im_addr2, im_instr2, ins2, pc2, p42;
    logic        im_en1, iv1, im_en2, iv2;
    logic [2:0]  occ1, occ2;
    logic [31:0] b2_stage;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_pc [2];
    logic [31:0] iss_pc [2];
    int          since [2];

    fetch_prefetch_unit #(.WIDTH(32), .DEPTH(4), .BRAM_LATENCY(1), .RESET_PC(32'h0)) u_dut_l1 (
        .clk(clk), .rst(rst), .im_addr(im_addr1), .im_en(im_en1), .im_instr(im_instr1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .instr_valid(iv1), .instrF(ins1), .pcF(pc1), .pc_plus4F(p41), .occupancy(occ1)
    );

    fetch_prefetch_unit #(.WIDTH(32), .DEPTH(4), .BRAM_LATENCY(2), .RESET_PC(32'h0)) u_dut_l2 (
        .clk(clk), .rst(rst), .im_addr(im_addr2), .im_en(im_en2), .im_instr(im_instr2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .instr_valid(iv2), .instrF(ins2), .pcF(pc2), .pc_plus4F(p42), .occupancy(occ2)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models; unrequested cycles return garbage so stray pushes are visible.
    always @(posedge clk) im_instr1 <= im_en1 ? mem_fn(im_addr1) : $urandom;
    always @(posedge clk) begin
        b2_stage  <= im_en2 ? mem_fn(im_addr2) : $urandom;
        im_instr2 <= b2_stage;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected behaviour: the issue stream and the presented stream both walk the program
    // from the restart point in steps of 4; the head appears exactly lat cycles after the
    // restart issue and never disappears while no redirect occurs.
    task automatic model_step(input int d, input int lat, input logic en, input logic [31:0] addr,
                              input logic v, input logic [31:0] ins, input logic [31:0] pc,
                              input logic [31:0] p4, input logic [2:0] occ);
        string s;
        s = (d == 0) ? "L1" : "L2";
        if (!rst) begin
            check_eq({s, "_rst_en"}, 32'(en), 32'd0);
            check_eq({s, "_rst_valid"}, 32'(v), 32'd0);
            check_eq({s, "_rst_addr"}, addr, 32'h0);
            check_eq({s, "_rst_pcF"}, pc, 32'h0);
            check_eq({s, "_rst_instrF"}, ins, 32'h0);
            check_eq({s, "_rst_plus4"}, p4, 32'h0);
            check_eq({s, "_rst_occ"}, 32'(occ), 32'd0);
            exp_pc[d] = 32'h0;
            iss_pc[d] = 32'h0;
            since[d]  = -1;
        end else if (redirect_valid) begin
            check_eq({s, "_redir_en"}, 32'(en), 32'd0);
            exp_pc[d] = redirect_pc & ~32'h3;
            iss_pc[d] = redirect_pc & ~32'h3;
            since[d]  = -1;
        end else begin
            if (since[d] < 1000) since[d]++;
            check_eq({s, "_valid"}, 32'(v), 32'(since[d] >= lat));
            check_eq({s, "_occ_bound"}, 32'(occ <= 3'd4), 32'd1);
            check_eq({s, "_credit"}, 32'(en && occ == 3'd4), 32'd0);
            if (since[d] == 0) check_eq({s, "_restart_en"}, 32'(en), 32'd1);
            if (en) begin
                check_eq({s, "_issue_addr"}, addr, iss_pc[d]);
                iss_pc[d] = iss_pc[d] + 32'd4;
            end
            if (v) begin
                check_eq({s, "_pcF"}, pc, exp_pc[d]);
                check_eq({s, "_instrF"}, ins, mem_fn(exp_pc[d]));
                check_eq({s, "_plus4"}, p4, exp_pc[d] + 32'd4);
                if (!stall) exp_pc[d] = exp_pc[d] + 32'd4;
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 1, im_en1, im_addr1, iv1, ins1, pc1, p41, occ1);
        model_step(1, 2, im_en2, im_addr2, iv2, ins2, pc2, p42, occ2);
    end

    task automatic cyc(input logic st, input logic rv, input logic [31:0] rp);
        @(posedge clk);
        #1;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rp;
    endtask

    task automatic reset_pulse(input logic st);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        stall          = st;
        redirect_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("a_l1_addr_seq", im_addr1, 32'(4 * i));
            check_eq("a_l1_en_seq", 32'(im_en1), 32'd1);
        end
        repeat (6) cyc(1'b0, 1'b0, 32'h0);

        reset_pulse(1'b1);
        repeat (9) cyc(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check_eq("b_l2_occ_full", 32'(occ2), 32'd4);
        check_eq("b_l2_en_off", 32'(im_en2), 32'd0);
        check_eq("b_l2_head", pc2, 32'h0);
        check_eq("b_l1_occ_full", 32'(occ1), 32'd4);
        repeat (20) cyc(1'b0, 1'b0, 32'h0);

        repeat (6) cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h100);
        cyc(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_eq("c_l1_occ_flush", 32'(occ1), 32'd0);
        check_eq("c_l2_occ_flush", 32'(occ2), 32'd0);
        check_eq("c_l2_target_addr", im_addr2, 32'h100);
        repeat (8) cyc(1'b0, 1'b0, 32'h0);

        cyc(1'b0, 1'b1, 32'h203);
        repeat (8) cyc(1'b0, 1'b0, 32'h0);

        cyc(1'b0, 1'b1, 32'h40);
        cyc(1'b0, 1'b1, 32'h80);
        repeat (8) cyc(1'b0, 1'b0, 32'h0);

        reset_pulse(1'b0);
        repeat (10) cyc(1'b0, 1'b0, 32'h0);

        cyc(1'b0, 1'b1, 32'hFFFF_FFF4);
        repeat (8) cyc(1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) reset_pulse(1'($urandom_range(0, 1)));
            else cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, $urandom);
        end
        cyc(1'b0, 1'b0, 32'h0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
